// File: rtl/expipe_pkg.sv
// expipe_pkg: shared execution-pipeline types.
//   cdb_data_t  - word broadcast on the Common Data Bus
//   CDB_N_REQ   - default number of reservation stations sharing the CDB
//   cdb_req_e   - requester index of each reservation station on the CDB
package expipe_pkg;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] value;
        logic        except_raised;
        logic [3:0]  except_code;
    } cdb_data_t;

    localparam int CDB_N_REQ = 4;

    typedef enum logic [1:0] {
        CDB_REQ_BU  = 2'd0,
        CDB_REQ_ALU = 2'd1,
        CDB_REQ_LD  = 2'd2,
        CDB_REQ_ST  = 2'd3
    } cdb_req_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: handshake bundle between the reservation stations, the CDB
// arbiter and the ROB/snoop consumers.
//   rs_valid_i / rs_data_i / rs_ready_o : per-RS result handshake
//   rob_ready_i                         : consumers accept the current word
//   cdb_valid_o / cdb_data_o            : registered broadcast word
// slave  = arbiter side, master = environment (RS + ROB) side.
interface cdb_arbiter_if
    import expipe_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ
);
    logic [N_REQ-1:0]      rs_valid_i;
    logic [N_REQ-1:0]      rs_ready_o;
    cdb_data_t [N_REQ-1:0] rs_data_i;
    logic                  rob_ready_i;
    logic                  cdb_valid_o;
    cdb_data_t             cdb_data_o;

    modport slave (
        input  rs_valid_i,
        input  rs_data_i,
        input  rob_ready_i,
        output rs_ready_o,
        output cdb_valid_o,
        output cdb_data_o
    );

    modport master (
        output rs_valid_i,
        output rs_data_i,
        output rob_ready_i,
        input  rs_ready_o,
        input  cdb_valid_o,
        input  cdb_data_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req : request vector
//   ptr : index holding highest priority this cycle (must be < N_REQ)
//   gnt : one-hot grant of the first request at or after ptr (wrapping), or 0
// The request vector is duplicated so the wrap-around scan becomes a plain
// lowest-set-bit search on a vector masked below ptr; folding the two halves
// back together yields the grant. Works for any N_REQ, not just powers of 2.
module rr_arbiter
    import expipe_pkg::*;
#(
    parameter int  N_REQ = CDB_N_REQ,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt
);

    localparam logic [2*N_REQ-1:0] ONE = {{(2*N_REQ-1){1'b0}}, 1'b1};

    logic [2*N_REQ-1:0] dbl_s;
    logic [2*N_REQ-1:0] mask_s;
    logic [2*N_REQ-1:0] masked_s;
    logic [2*N_REQ-1:0] first_s;

    // Keep only positions at or above ptr in the doubled request vector.
    always_comb begin
        mask_s = '0;
        for (int k = 0; k < 2 * N_REQ; k++) begin
            mask_s[k] = (k >= int'(ptr)) ? 1'b1 : 1'b0;
        end
    end

    assign dbl_s    = {req, req};
    assign masked_s = dbl_s & mask_s;
    // x & -x isolates the lowest set bit.
    assign first_s  = masked_s & (~masked_s + ONE);
    assign gnt      = first_s[N_REQ-1:0] | first_s[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the Common Data Bus between the reservation stations.
// Each cycle one pending result is picked round-robin and latched into a
// one-entry output register that drives the ROB and all RS snoop ports.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   flush_i : synchronous pipeline flush; kills the CDB word and any grant
//   cdb     : slave side of cdb_arbiter_if (RS handshakes, ROB ready, CDB)
// rs_ready_o is combinational from rs_valid_i, rob_ready_i and flush_i;
// cdb_valid_o/cdb_data_o come straight from registers.
module cdb_arbiter
    import expipe_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    cdb_arbiter_if.slave  cdb
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = $bits(cdb_data_t);

    logic [PW-1:0]    ptr_r;
    logic             out_valid_r;
    cdb_data_t        out_data_r;

    logic [N_REQ-1:0] grant_s;
    logic [N_REQ-1:0] ready_s;
    logic             load_en_s;
    logic             hs_s;
    logic [PW-1:0]    grant_idx_s;
    logic [PW-1:0]    ptr_nxt_s;
    logic [DW-1:0]    sel_data_s;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req (cdb.rs_valid_i),
        .ptr (ptr_r),
        .gnt (grant_s)
    );

    // The register can take a new word when empty or when its word drains now.
    assign load_en_s = ~out_valid_r | cdb.rob_ready_i;
    assign ready_s   = grant_s & {N_REQ{load_en_s & ~flush_i}};
    // Grant only covers requesting stations, so any ready bit is a handshake.
    assign hs_s      = |ready_s;

    // One-hot grant to index and data: OR-reduction over the gated requesters.
    always_comb begin
        grant_idx_s = '0;
        sel_data_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_idx_s = grant_idx_s | (PW'(i) & {PW{grant_s[i]}});
            sel_data_s  = sel_data_s | (cdb.rs_data_i[i] & {DW{grant_s[i]}});
        end
    end

    // Priority moves to the station after the winner, wrapping modulo N_REQ.
    always_comb begin
        if (int'(grant_idx_s) == N_REQ - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + PW'(1);
        end
    end

    // Output register and priority pointer; flush beats both load and drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            ptr_r       <= '0;
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
        end else if (hs_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= cdb_data_t'(sel_data_s);
            ptr_r       <= ptr_nxt_s;
        end else if (out_valid_r && cdb.rob_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign cdb.rs_ready_o  = ready_s;
    assign cdb.cdb_valid_o = out_valid_r;
    assign cdb.cdb_data_o  = out_data_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven check of cdb_arbiter (N_REQ = 4) with a
// scoreboard queue for broadcast words, plus hand-written sequences for
// asynchronous reset mid-operation and N_REQ = 3 wrap-around.
module tb_cdb_arbiter;
    import expipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush4;
    logic flush3;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(4)) bus4 ();
    cdb_arbiter_if #(.N_REQ(3)) bus3 ();

    cdb_arbiter #(.N_REQ(4)) dut4 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush4),
        .cdb     (bus4.slave)
    );

    cdb_arbiter #(.N_REQ(3)) dut3 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush3),
        .cdb     (bus3.slave)
    );

    typedef struct {
        logic       flush;
        logic [3:0] rs_valid;
        logic       rob_ready;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t      vecs [24];
    cdb_data_t sb_q [$];
    cdb_data_t last_word;
    int        checks = 0;
    int        errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cdb_data_t make_word(input int v, input int i);
        cdb_data_t w;
        w.rob_idx       = 6'(16 + i);
        w.value         = {8'hA0, 8'(v), 8'(i), 8'h5A};
        w.except_raised = 1'(i);
        w.except_code   = 4'(v);
        return w;
    endfunction

    // Pop the next expected word and compare it with the CDB.
    task automatic pop_and_check(input string name, input cdb_data_t act);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: CDB loaded %0h but scoreboard empty", name, act);
        end else begin
            last_word = sb_q.pop_front();
            check(name, 64'(act), 64'(last_word));
        end
    endtask

    task automatic step3(input logic [2:0] rv, input logic [2:0] exp_ready,
                         input logic [1:0] exp_ptr, input int tag);
        @(negedge clk);
        bus3.rs_valid_i  = rv;
        bus3.rob_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) bus3.rs_data_i[i] = make_word(tag, i);
        #1;
        check($sformatf("n3_t%0d rs_ready", tag), 64'(bus3.rs_ready_o), 64'(exp_ready));
        for (int i = 0; i < 3; i++) begin
            if (exp_ready[i]) sb_q.push_back(make_word(tag, i));
        end
        @(posedge clk);
        #1;
        check($sformatf("n3_t%0d cdb_valid", tag), 64'(bus3.cdb_valid_o), 64'(exp_ready != 3'b000));
        check($sformatf("n3_t%0d ptr", tag), 64'(dut3.ptr_r), 64'(exp_ptr));
        if (exp_ready != 3'b000) pop_and_check($sformatf("n3_t%0d cdb_data", tag), bus3.cdb_data_o);
    endtask

    initial begin
        //                flush  rs_valid rob_rdy exp_ready valid ptr
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd3};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3};
        vecs[9]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 2'd3};
        vecs[10] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
        vecs[13] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd2};
        vecs[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[18] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[19] = '{1'b1, 4'b1010, 1'b1, 4'b0000, 1'b0, 2'd2};
        vecs[20] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd0};
        vecs[21] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd2};
        vecs[22] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1};
        vecs[23] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

        rst_n            = 1'b0;
        flush4           = 1'b0;
        flush3           = 1'b0;
        bus4.rs_valid_i  = 4'b0000;
        bus4.rob_ready_i = 1'b0;
        bus3.rs_valid_i  = 3'b000;
        bus3.rob_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) bus4.rs_data_i[i] = '0;
        for (int i = 0; i < 3; i++) bus3.rs_data_i[i] = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst cdb_valid", 64'(bus4.cdb_valid_o), 64'd0);
        check("rst cdb_data", 64'(bus4.cdb_data_o), 64'd0);
        check("rst ptr", 64'(dut4.ptr_r), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post-rst rs_ready", 64'(bus4.rs_ready_o), 64'd0);

        // Table-driven vectors on the 4-requester instance
        for (int v = 0; v < 24; v++) begin
            @(negedge clk);
            flush4           = vecs[v].flush;
            bus4.rs_valid_i  = vecs[v].rs_valid;
            bus4.rob_ready_i = vecs[v].rob_ready;
            for (int i = 0; i < 4; i++) bus4.rs_data_i[i] = make_word(v, i);
            #1;
            check($sformatf("v%0d rs_ready", v), 64'(bus4.rs_ready_o), 64'(vecs[v].exp_ready));
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].exp_ready[i]) sb_q.push_back(make_word(v, i));
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d cdb_valid", v), 64'(bus4.cdb_valid_o), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d ptr", v), 64'(dut4.ptr_r), 64'(vecs[v].exp_ptr));
            if (vecs[v].exp_ready != 4'b0000) begin
                pop_and_check($sformatf("v%0d cdb_data", v), bus4.cdb_data_o);
            end else if (vecs[v].exp_valid) begin
                check($sformatf("v%0d cdb_data hold", v), 64'(bus4.cdb_data_o), 64'(last_word));
            end
        end

        // Asynchronous reset in the middle of a cycle with a valid word
        @(negedge clk);
        flush4           = 1'b0;
        bus4.rs_valid_i  = 4'b0001 << CDB_REQ_LD;
        bus4.rob_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) bus4.rs_data_i[i] = make_word(50, i);
        #1;
        check("mid-rst load rs_ready", 64'(bus4.rs_ready_o), 64'b0100);
        @(posedge clk);
        #1;
        check("mid-rst pre cdb_valid", 64'(bus4.cdb_valid_o), 64'd1);
        check("mid-rst pre ptr", 64'(dut4.ptr_r), 64'd3);
        bus4.rs_valid_i = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-rst cdb_valid", 64'(bus4.cdb_valid_o), 64'd0);
        check("mid-rst ptr", 64'(dut4.ptr_r), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid-rst release rs_ready", 64'(bus4.rs_ready_o), 64'd0);
        bus4.rs_valid_i = 4'b1111;
        for (int i = 0; i < 4; i++) bus4.rs_data_i[i] = make_word(51, i);
        #1;
        check("mid-rst first grant", 64'(bus4.rs_ready_o), 64'b0001);
        @(posedge clk);
        #1;
        check("mid-rst first word", 64'(bus4.cdb_data_o), 64'(make_word(51, 0)));
        @(negedge clk);
        bus4.rs_valid_i = 4'b0000;

        // Non-power-of-2 wrap on the 3-requester instance
        step3(3'b010, 3'b010, 2'd2, 100);
        step3(3'b001, 3'b001, 2'd1, 101);
        step3(3'b010, 3'b010, 2'd2, 102);
        step3(3'b101, 3'b100, 2'd0, 103);
        step3(3'b000, 3'b000, 2'd0, 104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single Common Data Bus between the execution-side reservation stations (branch, ALU, load, store, …).
- Each cycle it picks one pending result by round-robin and latches it into a one-entry output register.
- The output register drives `cdb_valid_o`/`cdb_data_o` toward the ROB and every RS snoop port.
- It sits between the per-unit RS `cdb_*` handshakes and the ROB write port.

## Interface
- `N_REQ`, default 4: number of requesting reservation stations; legal range 1..16.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; one clock, asynchronous, active-low.
- `flush_i`  in  1  synchronous pipeline flush (misprediction/exception).
- `rs_valid_i`  in  N_REQ  bit i: RS i holds a finished result.
- `rs_ready_o`  out  N_REQ  bit i: result of RS i accepted this cycle; one-hot or zero.
- `rs_data_i`  in  N_REQ × cdb_data_t  per-requester result (rob_idx, value, except_raised, except_code).
- `rob_ready_i`  in  1  ROB/consumers accept the current CDB word.
- `cdb_valid_o`  out  1  CDB carries a valid word.
- `cdb_data_o`  out  cdb_data_t  broadcast word.

## Operation
- **State**
  - `ptr`: round-robin priority pointer, $clog2(N_REQ) bits, minimum 1 bit.
  - Output register: `out_valid` and `out_data`.
- **Definitions**
  - `load_en` = ~out_valid | rob_ready_i.
  - `grant` = one-hot of the first i with rs_valid_i[i] = 1, scanning ptr, ptr+1, … N_REQ-1, 0, … ptr-1. Scan order is modulo N_REQ, explicitly correct for non-power-of-2 N_REQ. grant = 0 if no request.
  - `rs_ready_o` = grant & {N_REQ{load_en & ~flush_i}}. It is combinational and never asserted for a requester whose rs_valid_i is 0.
- **Handshake with RS i** completes when rs_valid_i[i] & rs_ready_o[i].
  - At that edge: out_data <= rs_data_i[i], out_valid <= 1, and ptr <= (i+1) mod N_REQ.
- **Drain with no new handshake**: if out_valid & rob_ready_i, then out_valid <= 0 and out_data holds.
- **Back-pressure**: if out_valid & ~rob_ready_i, the register holds its value and rs_ready_o = 0.
- **Flush**
  - out_valid <= 0; no grant that cycle; ptr unchanged.
  - Flush has priority over both load and drain.
- **ptr** changes only on a completed handshake. Idle cycles and back-pressure never move it.
- **N_REQ = 1**: ptr stays 0; the block degenerates to a registered valid/ready slice.
- **Requester contract**: a requester keeps rs_valid_i and rs_data_i stable until it sees rs_ready_o. The arbiter does not check this.
- **Fairness**: a continuously requesting RS is granted within N_REQ accepted transfers.

## Timing
- **Reset values**: cdb_valid_o = 0, cdb_data_o = '0, ptr = 0, rs_ready_o = 0 (no valid requests after reset).
- **Latency**: 1 cycle. A result accepted at edge t is on the CDB in cycle t+1.
- **Throughput**: 1 word/cycle while rob_ready_i = 1. Simultaneous drain of the old word and load of a new one is supported in the same cycle.
- **Reset mid-operation**: an asynchronous assertion immediately clears out_valid and ptr. Any in-flight word is lost; a flush always accompanies it at system level.
- **Combinational paths**
  - rs_ready_o depends combinationally on rs_valid_i, rob_ready_i and flush_i.
  - cdb_valid_o and cdb_data_o are register outputs with no combinational path from inputs.

## Structure
- **expipe_pkg**: `cdb_data_t` already lives there. Add the `CDB_N_REQ` constant (default requester count) and the requester-index enumeration (BU, ALU, LD, ST).
- **Sub-module `rr_arbiter`**
  - Parameter N_REQ; inputs req, ptr; output one-hot gnt. Pure combinational.
  - Implemented as a double-width masked priority encoder.
  - cdb_arbiter keeps ptr, the output register and the handshake logic.
- **Size**: about 150–250 lines of RTL total.

## Test plan
- **Reset**: assert rst_n_i = 0 mid-cycle with out_valid = 1 → cdb_valid_o drops immediately. After release, ptr = 0 and rs_ready_o = 0.
- **Round-robin, N_REQ = 4**: rs_valid_i = 4'b1111 held, rob_ready_i = 1.
  - Grants go 0, 1, 2, 3, 0 on consecutive cycles.
  - cdb_data_o.rob_idx follows the per-RS values one cycle later.
- **Back-pressure**: out_valid = 1, rob_ready_i = 0 for 3 cycles, rs_valid_i = 4'b0100.
  - rs_ready_o = 0 and cdb_data_o is stable.
  - In the cycle rob_ready_i = 1, rs_ready_o = 4'b0100 and the new word appears next cycle.
- **Flush collision**: flush_i = 1 with rs_valid_i = 4'b0011 and out_valid = 1 → rs_ready_o = 0, next cdb_valid_o = 0, ptr unchanged.
- **Non-power-of-2 wrap, N_REQ = 3**: ptr = 2, rs_valid_i = 3'b001 → grant 0 and ptr becomes 1. With ptr = 2 and rs_valid_i = 3'b101 → grant 2 and ptr wraps to 0.
- **Idle**: rs_valid_i = 0 for 5 cycles after a grant to RS 1 → ptr stays 2 and cdb_valid_o = 0 after the drain.
